hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Next-generation hazard and forwarding unit for the five-stage pipeline.
- Generalises register-address width and adds sequential stall control for two cases:
  - a multi-cycle mul/div unit sitting in EX;
  - a variable-latency data memory in MEM, using a ready handshake.
- Keeps load-use stall, EX-stage forwarding and misprediction/jump-register flush.
- Drives per-stage stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- REG_AW, 5, register-address width.
- MD_LAT, 4, mul/div latency in cycles; legal range is 2 to 64.
- CNT_W, 32, width of the performance counters (used only with HAZ_PERF_EN).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- rs_D, rt_D  in  REG_AW  source registers in ID
- rs_E, rt_E  in  REG_AW  source registers in EX
- write_reg_E/M/W  in  REG_AW  destination register per stage
- reg_write_E/M/W  in  1  writeback enables
- mem_to_reg_E  in  1  load in EX
- mem_req_M  in  1  memory access in MEM
- mem_ready_M  in  1  memory completes this cycle
- md_start_E  in  1  mul/div instruction present in EX
- mispredict_E  in  1  branch outcome differs from prediction
- jumpR_E  in  1  register jump resolved in EX
- stall_F, stall_D, stall_E, stall_M  out  1  hold the stage register
- flush_D, flush_E, flush_M, flush_W  out  1  insert a bubble into the stage register
- forward_A_E, forward_B_E  out  2  00 = regfile, 01 = from MEM, 10 = from WB
- md_busy  out  1  mul/div in progress

Behaviour:
- Reset: the FSM goes to RUN and the counter clears. During reset every output is 0, including forward_A_E, forward_B_E and md_busy.
- Forwarding (combinational):
  - Select 01 when reg_write_M is set, write_reg_M ≠ 0 and write_reg_M equals the source.
  - Otherwise select 10 on the same test against W.
  - MEM has priority over WB. Register 0 is never forwarded.
- FSM states are RUN, MD_BUSY and MEM_WAIT. Priority, highest first:
  1. MEM_WAIT
  2. MD_BUSY
  3. redirect
  4. load-use
- MEM_WAIT:
  - Entered combinationally in any state when mem_req_M is set and mem_ready_M is not.
  - stall_F/D/E/M = 1 and flush_W = 1.
  - A MD_BUSY count is frozen while in MEM_WAIT.
  - Leaves in the cycle mem_ready_M = 1 and returns to the previous state.
- MD_BUSY:
  - Entered from RUN when md_start_E = 1; the counter loads MD_LAT−1.
  - stall_F/D/E = 1, flush_M = 1 and md_busy = 1 from the start cycle through the cycle the counter is 1.
  - Returns to RUN when the counter reaches 0; the E instruction advances that cycle.
  - md_start_E is ignored while in MD_BUSY.
- Redirect:
  - A redirect is mispredict_E or jumpR_E.
  - In RUN with no MEM_WAIT: flush_D = 1 and flush_E = 1.
  - It overrides load-use: stall_F and stall_D are 0 that cycle.
  - During MD_BUSY or MEM_WAIT the redirect is held in EX and its flush is issued in the release cycle.
- Load-use:
  - Applies in RUN with no redirect.
  - Condition: mem_to_reg_E = 1, write_reg_E ≠ 0, and write_reg_E equals rs_D or rt_D.
  - Response: stall_F = 1, stall_D = 1, flush_E = 1, lasting exactly one cycle.
- Simultaneous md_start_E and load-use: MD_BUSY wins and the load-use condition is re-evaluated on release.
- Asserting rst mid-operation aborts MD_BUSY or MEM_WAIT immediately.

Optional Feature:
HAZ_PERF_EN
- Defined: adds outputs stall_cycles and flush_events, each CNT_W bits.
  - stall_cycles counts cycles with stall_F = 1.
  - flush_events counts cycles with flush_D = 1.
  - Both saturate at all-ones and clear on rst.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - forwarding codes FWD_RF, FWD_MEM, FWD_WB;
  - the FSM state enum;
  - a function for the counter width, clog2(MD_LAT).
- One sub-module, hazard_md_counter: load, decrement, hold and zero-detect. It holds its count while frozen.

Test Plan:
- Forwarding: rs_E = 3, reg_write_M = 1 with write_reg_M = 3, and write_reg_W = 3 → forward_A_E = 01. With write_reg_M = 0 → 10. With rs_E = 0 → 00.
- Load-use: mem_to_reg_E = 1, write_reg_E = 5, rt_D = 5 → for 1 cycle stall_F = stall_D = flush_E = 1. Then all are 0.
- Mul/div, MD_LAT = 4: md_start_E pulse → md_busy, stall_E and flush_M high for exactly 4 cycles, then low.
- Memory wait: mem_req_M = 1 with mem_ready_M low for 3 cycles → stall_M = flush_W = 1 for 3 cycles, dropping the cycle ready rises. The same test during MD_BUSY extends md_busy by 3 cycles.
- Redirect and load-use in the same cycle: mispredict_E together with the load-use condition → flush_D = flush_E = 1 and stall_F = 0. Redirect during MD_BUSY → flush_D is 1 only in the release cycle.
- Reset mid-operation: rst in the 2nd MD_BUSY cycle → all outputs 0 asynchronously and RUN on release. With HAZ_PERF_EN, stall_cycles = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared forwarding codes, FSM states and sizing helper for the hazard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Width of the mul/div down-counter; it must hold MD_LAT-1.
  function automatic int md_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Mul/div latency down-counter: load MD_LAT-1, decrement to zero, hold while frozen.
module hazard_md_counter
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic freeze,
  output logic zero
);

  localparam int W = md_cnt_w(MD_LAT);
  localparam logic [W-1:0] INIT = W'(MD_LAT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt_q <= INIT;
      end else if (dec && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard, forwarding and sequential stall/flush control for the five-stage pipeline.
// Define HAZ_PERF_EN to add the saturating stall_cycles/flush_events counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] write_reg_E,
  input  logic [REG_AW-1:0] write_reg_M,
  input  logic [REG_AW-1:0] write_reg_W,
  input  logic              reg_write_E,
  input  logic              reg_write_M,
  input  logic              reg_write_W,
  input  logic              mem_to_reg_E,
  input  logic              mem_req_M,
  input  logic              mem_ready_M,
  input  logic              md_start_E,
  input  logic              mispredict_E,
  input  logic              jumpR_E,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_M,
  output logic              flush_W,
  output logic [1:0]        forward_A_E,
  output logic [1:0]        forward_B_E,
  output logic              md_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  if (MD_LAT < 2 || MD_LAT > 64 || CNT_W < 1) begin : g_bad_param
    $error("hazard_unit_mc: MD_LAT must be 2..64 and CNT_W at least 1");
  end

  state_t state_q, state_d, ret_q, ret_d, base;
  logic   mem_stall, redirect, load_use, busy_now;
  logic   md_zero, md_load, md_dec, lu_q, lu_fire;

  // A load always writes back, so reg_write_E adds nothing to the load-use test.
  logic unused_reg_write_E;
  assign unused_reg_write_E = reg_write_E;

  assign mem_stall = mem_req_M & ~mem_ready_M;
  assign redirect  = mispredict_E | jumpR_E;
  assign base      = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign busy_now  = ((base == RUN) && md_start_E) || ((base == MD_BUSY) && !md_zero);
  // lu_q suppresses a second stall for the same load; E holds a bubble by then.
  assign load_use  = mem_to_reg_E && (write_reg_E != '0) && !lu_q &&
                     ((write_reg_E == rs_D) || (write_reg_E == rt_D));

  always_comb begin
    forward_A_E = FWD_RF;
    forward_B_E = FWD_RF;
    if (!rst) begin
      if (reg_write_M && (write_reg_M != '0) && (write_reg_M == rs_E))
        forward_A_E = FWD_MEM;
      else if (reg_write_W && (write_reg_W != '0) && (write_reg_W == rs_E))
        forward_A_E = FWD_WB;
      if (reg_write_M && (write_reg_M != '0) && (write_reg_M == rt_E))
        forward_B_E = FWD_MEM;
      else if (reg_write_W && (write_reg_W != '0) && (write_reg_W == rt_E))
        forward_B_E = FWD_WB;
    end
  end

  always_comb begin
    state_d = base;
    ret_d   = ret_q;
    md_load = 1'b0;
    md_dec  = 1'b0;
    lu_fire = 1'b0;
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    flush_W = 1'b0;
    md_busy = busy_now;
    if (mem_stall) begin
      state_d = MEM_WAIT;
      ret_d   = base;
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else begin
      case (base)
        RUN: begin
          if (md_start_E) begin
            state_d = MD_BUSY;
            md_load = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_zero) state_d = RUN;
          else md_dec = 1'b1;
        end
        default: state_d = RUN;
      endcase
      // The zero-count MD_BUSY cycle is the release: held redirects and load-use resolve here.
      if (busy_now) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        flush_M = 1'b1;
      end else if (redirect) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        lu_fire = 1'b1;
      end
    end
    if (rst) begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_M = 1'b0;
      flush_W = 1'b0;
      md_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      lu_q    <= lu_fire;
    end
  end

  hazard_md_counter #(.MD_LAT(MD_LAT)) u_md_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (md_load),
    .dec    (md_dec),
    .freeze (mem_stall),
    .zero   (md_zero)
  );

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_F && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_D && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule
